dual_issue_fetch_buffer: RTL

Instruction-pair buffer directly upstream of the dual-issue decoder. Accepts one fetched instruction per cycle from the icache/fetch path, holds up to `els_p` entries in program order, and presents the two oldest entries as an issue pair. Each cycle the decode stage consumes either one or two entries according to its single-issue decision; any unconsumed second entry becomes the next pair's first slot. A flush input empties the buffer on a PC redirect.

---
 rtl/dual_issue_fetch_buffer.sv | 106 ++++++++++
 1 files changed

// File: rtl/dual_issue_fetch_buffer.sv
// dual_issue_fetch_buffer
// Holds fetched instructions in program order and shows the two oldest entries
// to the dual-issue decoder as an issue pair.
// Ports:
//   clk_i, reset_i       clock, asynchronous active-high reset
//   flush_i              empties the buffer on a PC redirect
//   v_i, instr_i, pc_i   push side (one instruction per cycle), ready_o back
//   v_o, instr_o, pc_o   issue pair, slot 0 oldest; invalid slots show NOP / pc 0
//   yumi_i               decode consumes this cycle
//   single_issue_i       with yumi_i, consume slot 0 only
//   count_o              current occupancy
module dual_issue_fetch_buffer #(
    parameter int unsigned els_p       = 4,
    parameter int unsigned pc_width_p  = 22,
    parameter logic [31:0] nop_instr_p = 32'h0000_0013
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic                          v_i,
    input  logic [31:0]                   instr_i,
    input  logic [pc_width_p-1:0]         pc_i,
    output logic                          ready_o,
    output logic [1:0]                    v_o,
    output logic [31:0]                   instr_o [0:1],
    output logic [pc_width_p-1:0]         pc_o    [0:1],
    input  logic                          yumi_i,
    input  logic                          single_issue_i,
    output logic [$clog2(els_p+1)-1:0]    count_o
);

    localparam int unsigned ptr_w = $clog2(els_p);
    localparam int unsigned cnt_w = $clog2(els_p + 1);

    logic [31:0]           instr_mem [els_p];
    logic [pc_width_p-1:0] pc_mem    [els_p];

    logic [ptr_w-1:0] rd_ptr, wr_ptr, rd_ptr_1;
    logic [cnt_w-1:0] count, count_next;
    logic [1:0]       v;
    logic [1:0]       pop_n;
    logic             ready;
    logic             push;

    // Status decoded from registered occupancy only.
    always_comb begin
        ready = (count != cnt_w'(els_p));
        v[0]  = (count != '0);
        v[1]  = (count >= cnt_w'(2));
    end

    // Handshakes and occupancy update; a pop on an empty buffer is ignored.
    always_comb begin
        push  = v_i & ready & ~flush_i;
        pop_n = 2'd0;
        if (yumi_i && v[0]) begin
            pop_n = (single_issue_i || !v[1]) ? 2'd1 : 2'd2;
        end
        count_next = count + cnt_w'(push) - cnt_w'(pop_n);
    end

    // Pointer and occupancy state; flush wins over push and pop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + ptr_w'(pop_n);
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            count <= count_next;
        end
    end

    // Storage is left unreset; every read is masked by slot valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr] <= instr_i;
            pc_mem[wr_ptr]    <= pc_i;
        end
    end

    // Issue pair read from the two oldest entries, wrapping naturally.
    always_comb begin
        rd_ptr_1   = rd_ptr + ptr_w'(1);
        ready_o    = ready;
        v_o        = v;
        count_o    = count;
        instr_o[0] = v[0] ? instr_mem[rd_ptr]   : nop_instr_p;
        pc_o[0]    = v[0] ? pc_mem[rd_ptr]      : '0;
        instr_o[1] = v[1] ? instr_mem[rd_ptr_1] : nop_instr_p;
        pc_o[1]    = v[1] ? pc_mem[rd_ptr_1]    : '0;
    end

    // Decode must not consume from an empty buffer.
    yumi_on_empty_a: assert property (
        @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v[0])
    ) else $error("dual_issue_fetch_buffer: yumi_i asserted while empty");

endmodule
